// File: rtl/fc_argmax_pkg.sv
// fc_argmax_pkg
// Shared types and helpers for the fc_argmax classifier stage.
//   state_e   : top-level FSM states (HOLD exists only in the non-overlap build)
//   idx_width : width of an index into an M-element vector, never below 1
package fc_argmax_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    function automatic int idx_width(input int m);
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/fc_argmax_if.sv
// fc_argmax_if
// Groups both handshakes of fc_argmax.
//   input side : input_valid, input_ready, input_data[T-1:0]
//   output side: output_valid, output_ready, output_index[IW-1:0], output_max[T-1:0]
//   slave  : view of fc_argmax itself
//   master : view of the environment (fc layer upstream plus the next consumer)
interface fc_argmax_if
    import fc_argmax_pkg::*;
#(
    parameter int M = 4,
    parameter int T = 12
);
    localparam int IW = idx_width(M);

    logic          input_valid;
    logic          input_ready;
    logic [T-1:0]  input_data;
    logic          output_valid;
    logic          output_ready;
    logic [IW-1:0] output_index;
    logic [T-1:0]  output_max;

    modport slave (
        input  input_valid, input_data, output_ready,
        output input_ready, output_valid, output_index, output_max
    );

    modport master (
        output input_valid, input_data, output_ready,
        input  input_ready, output_valid, output_index, output_max
    );

endinterface

// File: rtl/fc_argmax_track.sv
// fc_argmax_track
// Element counter plus running signed maximum over one vector.
//   clk, reset : clock, async active-high reset
//   accept_i   : an element is transferred this cycle
//   data_i     : the element (signed, T bits)
//   last_o     : current element position is M-1
//   idx_o/val_o: argmax/max including the element on data_i (valid when
//                accept_i && last_o, used by the top to load the result)
module fc_argmax_track
    import fc_argmax_pkg::*;
#(
    parameter int M = 4,
    parameter int T = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     accept_i,
    input  logic [T-1:0]             data_i,
    output logic                     last_o,
    output logic [idx_width(M)-1:0]  idx_o,
    output logic [T-1:0]             val_o
);
    localparam int            IW   = idx_width(M);
    localparam logic [IW-1:0] LAST = IW'(M - 1);

    logic [IW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] best_idx_q, best_idx_d;
    logic [T-1:0]  best_val_q, best_val_d;

    assign last_o = (cnt_q == LAST);

    // Strict compare: ties keep the earlier (lower) index.
    always_comb begin
        idx_o = best_idx_q;
        val_o = best_val_q;
        if ((cnt_q == '0) || ($signed(data_i) > $signed(best_val_q))) begin
            idx_o = cnt_q;
            val_o = data_i;
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        if (accept_i) begin
            cnt_d      = last_o ? '0 : cnt_q + IW'(1);
            best_idx_d = idx_o;
            best_val_d = val_o;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
        end
    end

endmodule

// File: rtl/fc_argmax.sv
// fc_argmax
// Argmax classifier behind the fc layer: M signed T-bit activations in,
// one (index, max) result out per vector, valid/ready on both sides.
//   clk, reset : clock, async active-high reset
//   bus        : fc_argmax_if.slave (input_* from fc layer, output_* to consumer)
// Build option: FC_ARGMAX_OVERLAP_EN
//   undefined : COLLECT/HOLD; input stalls while a result is pending
//   defined   : no HOLD; next vector is collected while the result is
//               presented, stalling only its last element
//
// state   | meaning
// COLLECT | accepting elements of the current vector
// HOLD    | result pending, input stalled (non-overlap build only)
module fc_argmax
    import fc_argmax_pkg::*;
#(
    parameter int M = 4,
    parameter int T = 12
) (
    input logic        clk,
    input logic        reset,
    fc_argmax_if.slave bus
);
    localparam int IW = idx_width(M);

    logic          accept;
    logic          out_hs;
    logic          in_ready;
    logic          last;
    logic [IW-1:0] fin_idx;
    logic [T-1:0]  fin_val;

    logic          out_valid_q;
    logic [IW-1:0] out_idx_q;
    logic [T-1:0]  out_max_q;

    assign accept = bus.input_valid && in_ready;
    assign out_hs = out_valid_q && bus.output_ready;

    fc_argmax_track #(.M(M), .T(T)) u_track (
        .clk      (clk),
        .reset    (reset),
        .accept_i (accept),
        .data_i   (bus.input_data),
        .last_o   (last),
        .idx_o    (fin_idx),
        .val_o    (fin_val)
    );

`ifdef FC_ARGMAX_OVERLAP_EN
    // Only the last element needs the result register free; it may go in on
    // the same edge that hands the old result off.
    assign in_ready = !reset && !(last && out_valid_q && !bus.output_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_max_q   <= '0;
        end else if (accept && last) begin
            out_valid_q <= 1'b1;
            out_idx_q   <= fin_idx;
            out_max_q   <= fin_val;
        end else if (out_hs) begin
            out_valid_q <= 1'b0;
        end
    end
`else
    state_e state_q;

    assign in_ready = !reset && (state_q == COLLECT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= COLLECT;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_max_q   <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept && last) begin
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                        out_idx_q   <= fin_idx;
                        out_max_q   <= fin_val;
                    end
                end
                HOLD: begin
                    if (out_hs) begin
                        state_q     <= COLLECT;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end
`endif

    assign bus.input_ready  = in_ready;
    assign bus.output_valid = out_valid_q;
    assign bus.output_index = out_idx_q;
    assign bus.output_max   = out_max_q;

endmodule
